// File: rtl/mul_issue_ctrl.sv
// Issue sequencer for the multi-cycle 64x64 multiplier. It drives the hold-flag handshake,
// stalls Ex while a product is pending, and formats the write-back result.
// A one-entry product cache lets a MUL issued after a MULH* on the same operands skip the multiply.
module mul_issue_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      ReqValid,
    input  logic [6:0]                ReqOpCode,
    input  logic [2:0]                ReqFunct3,
    input  logic [4:0]                ReqRd,
    input  logic [DATA_WIDTH-1:0]     ReqSrc1,
    input  logic [DATA_WIDTH-1:0]     ReqSrc2,
    input  logic                      Flush,
    output logic [1:0]                MulHoldFlag,
    output logic [DATA_WIDTH-1:0]     MulSrc1,
    output logic [DATA_WIDTH-1:0]     MulSrc2,
    output logic [6:0]                MulOpCode,
    output logic [2:0]                MulFunct3,
    output logic [4:0]                MulRd,
    input  logic                      MulDone,
    input  logic [2*DATA_WIDTH-1:0]   MulProduct,
    output logic                      StallReq,
    output logic                      RespValid,
    output logic [4:0]                RespRd,
    output logic [DATA_WIDTH-1:0]     RespData,
    output logic                      TimeoutErr
);

    localparam logic [6:0] OP_64 = 7'b0110011;
    localparam logic [6:0] OP_W  = 7'b0111011;
    localparam int         CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, START, BUSY, DONE, ABORT} state_t;

    state_t                    state, stateNext;
    logic [CNT_W-1:0]          wdCnt;
    logic                      cacheValid;
    logic [DATA_WIDTH-1:0]     cacheSrc1, cacheSrc2;
    logic [2:0]                cacheFunct3;
    logic [2*DATA_WIDTH-1:0]   cacheProd;
    logic [DATA_WIDTH-1:0]     resultQ;
    logic                      accept, cacheHit, wdExpired;
    logic                      captureProd, invalidate, setTimeout;

    function automatic logic [DATA_WIDTH-1:0] fmtResult(
        input logic [2*DATA_WIDTH-1:0] prod,
        input logic [6:0]              opCode,
        input logic [2:0]              funct3
    );
        if (opCode == OP_W)
            return {{(DATA_WIDTH-32){prod[31]}}, prod[31:0]};
        else if (funct3 == 3'b000)
            return prod[DATA_WIDTH-1:0];
        else
            return prod[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    assign accept    = ReqValid && !Flush;
    assign wdExpired = (wdCnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // Low 64 bits do not depend on operand signedness, so MUL may reuse any cached MULH* product.
    assign cacheHit  = cacheValid && (ReqOpCode == OP_64) &&
                       (ReqSrc1 == cacheSrc1) && (ReqSrc2 == cacheSrc2) &&
                       ((ReqFunct3 == cacheFunct3) || (ReqFunct3 == 3'b000));

    always_comb begin
        stateNext   = state;
        captureProd = 1'b0;
        invalidate  = 1'b0;
        setTimeout  = 1'b0;
        MulHoldFlag = 2'b00;
        StallReq    = 1'b0;
        RespValid   = 1'b0;
        case (state)
            IDLE: begin
                StallReq = accept;
                if (accept)
                    stateNext = cacheHit ? DONE : START;
            end
            START: begin
                MulHoldFlag = 2'b01;
                StallReq    = 1'b1;
                if (Flush) begin
                    invalidate = 1'b1;
                    stateNext  = ABORT;
                end else begin
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                MulHoldFlag = 2'b10;
                StallReq    = 1'b1;
                if (Flush) begin
                    invalidate = 1'b1;
                    stateNext  = MulDone ? IDLE : ABORT;
                end else if (MulDone) begin
                    captureProd = 1'b1;
                    stateNext   = DONE;
                end else if (wdExpired) begin
                    setTimeout = 1'b1;
                    invalidate = 1'b1;
                    stateNext  = IDLE;
                end
            end
            DONE: begin
                RespValid = !Flush;
                stateNext = IDLE;
            end
            ABORT: begin
                StallReq   = 1'b1;
                invalidate = 1'b1;
                if (MulDone) begin
                    stateNext = IDLE;
                end else if (wdExpired) begin
                    setTimeout = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            wdCnt      <= '0;
            TimeoutErr <= 1'b0;
            cacheValid <= 1'b0;
            MulOpCode  <= '0;
            MulFunct3  <= '0;
            MulRd      <= '0;
            MulSrc1    <= '0;
            MulSrc2    <= '0;
            resultQ    <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && accept)
                wdCnt <= '0;
            else if (state == BUSY || state == ABORT)
                wdCnt <= wdCnt + CNT_W'(1);
            if (setTimeout)
                TimeoutErr <= 1'b1;
            if (invalidate)
                cacheValid <= 1'b0;
            else if (captureProd && MulOpCode == OP_64)
                cacheValid <= 1'b1;
            if (state == IDLE && accept) begin
                MulOpCode <= ReqOpCode;
                MulFunct3 <= ReqFunct3;
                MulRd     <= ReqRd;
                MulSrc1   <= ReqSrc1;
                MulSrc2   <= ReqSrc2;
                if (cacheHit)
                    resultQ <= fmtResult(cacheProd, ReqOpCode, ReqFunct3);
            end
            if (captureProd)
                resultQ <= fmtResult(MulProduct, MulOpCode, MulFunct3);
        end
    end

    // Cache payload is qualified by cacheValid, so it needs no reset.
    always_ff @(posedge Clk) begin
        if (captureProd && MulOpCode == OP_64) begin
            cacheSrc1   <= MulSrc1;
            cacheSrc2   <= MulSrc2;
            cacheFunct3 <= MulFunct3;
            cacheProd   <= MulProduct;
        end
    end

    assign RespRd   = MulRd;
    assign RespData = resultQ;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl; the bench itself plays the multiplier with hand-computed products.
module tb_mul_issue_ctrl;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         ReqValid;
    logic [6:0]   ReqOpCode;
    logic [2:0]   ReqFunct3;
    logic [4:0]   ReqRd;
    logic [63:0]  ReqSrc1, ReqSrc2;
    logic         Flush;
    logic [1:0]   MulHoldFlag;
    logic [63:0]  MulSrc1, MulSrc2;
    logic [6:0]   MulOpCode;
    logic [2:0]   MulFunct3;
    logic [4:0]   MulRd;
    logic         MulDone;
    logic [127:0] MulProduct;
    logic         StallReq, RespValid, TimeoutErr;
    logic [4:0]   RespRd;
    logic [63:0]  RespData;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] OP64 = 7'b0110011;
    localparam logic [6:0] OPW  = 7'b0111011;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    mul_issue_ctrl #(.DATA_WIDTH(64), .TIMEOUT_CYCLES(64)) dut (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqOpCode(ReqOpCode),
        .ReqFunct3(ReqFunct3), .ReqRd(ReqRd), .ReqSrc1(ReqSrc1), .ReqSrc2(ReqSrc2),
        .Flush(Flush), .MulHoldFlag(MulHoldFlag), .MulSrc1(MulSrc1), .MulSrc2(MulSrc2),
        .MulOpCode(MulOpCode), .MulFunct3(MulFunct3), .MulRd(MulRd), .MulDone(MulDone),
        .MulProduct(MulProduct), .StallReq(StallReq), .RespValid(RespValid),
        .RespRd(RespRd), .RespData(RespData), .TimeoutErr(TimeoutErr)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [63:0] s1, input logic [63:0] s2);
        ReqValid = 1'b1; ReqOpCode = op; ReqFunct3 = f3; ReqRd = rd;
        ReqSrc1 = s1; ReqSrc2 = s2;
        step();
        ReqValid = 1'b0;
    endtask

    // Called in the START cycle; returns in the DONE cycle.
    task automatic feedDone(input int nBusy, input logic [127:0] prod);
        step();
        for (int i = 1; i < nBusy; i++) step();
        MulDone = 1'b1; MulProduct = prod;
        step();
        MulDone = 1'b0; MulProduct = '0;
    endtask

    initial begin
        logic [1:0] expFlag [6];
        expFlag = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        Rst = 1'b0; ReqValid = 1'b0; ReqOpCode = '0; ReqFunct3 = '0; ReqRd = '0;
        ReqSrc1 = '0; ReqSrc2 = '0; Flush = 1'b0; MulDone = 1'b0; MulProduct = '0;

        #3;
        chk("rst_flag", 64'(MulHoldFlag), 64'd0);
        chk("rst_stall", 64'(StallReq), 64'd0);
        chk("rst_resp", 64'(RespValid), 64'd0);
        chk("rst_data", RespData, 64'd0);
        chk("rst_tmo", 64'(TimeoutErr), 64'd0);
        step(); step();
        Rst = 1'b1;
        step();

        // Miss MUL 3 * -5, product returns in the 4th BUSY cycle
        ReqValid = 1'b1; ReqOpCode = OP64; ReqFunct3 = 3'b000; ReqRd = 5'd5;
        ReqSrc1 = 64'd3; ReqSrc2 = 64'hFFFF_FFFF_FFFF_FFFB;
        #1;
        chk("mul_stall_idle", 64'(StallReq), 64'd1);
        step();
        ReqValid = 1'b0;
        chk("mul_src1", MulSrc1, 64'd3);
        chk("mul_src2", MulSrc2, 64'hFFFF_FFFF_FFFF_FFFB);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("mul_flag_c%0d", i + 1), 64'(MulHoldFlag), 64'(expFlag[i]));
            chk($sformatf("mul_resp_c%0d", i + 1), 64'(RespValid), (i == 5) ? 64'd1 : 64'd0);
            if (i == 4) begin
                MulDone = 1'b1; MulProduct = {ONES, 64'hFFFF_FFFF_FFFF_FFF1};
            end
            if (i < 5) step();
            MulDone = 1'b0; MulProduct = '0;
        end
        chk("mul_data", RespData, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("mul_rd", 64'(RespRd), 64'd5);
        chk("mul_stall_done", 64'(StallReq), 64'd0);
        step();
        chk("mul_resp_idle", 64'(RespValid), 64'd0);

        // MULHU all-ones, then MUL on the same operands hits the cache
        issue(OP64, 3'b011, 5'd7, ONES, ONES);
        chk("mulhu_flag", 64'(MulHoldFlag), 64'd1);
        feedDone(1, {64'hFFFF_FFFF_FFFF_FFFE, 64'd1});
        chk("mulhu_resp", 64'(RespValid), 64'd1);
        chk("mulhu_data", RespData, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mulhu_rd", 64'(RespRd), 64'd7);
        step();
        issue(OP64, 3'b000, 5'd8, ONES, ONES);
        chk("hit_resp", 64'(RespValid), 64'd1);
        chk("hit_flag", 64'(MulHoldFlag), 64'd0);
        chk("hit_data", RespData, 64'd1);
        chk("hit_rd", 64'(RespRd), 64'd8);
        step();
        chk("hit_idle_resp", 64'(RespValid), 64'd0);

        // MULW sign-extension; repeat misses
        issue(OPW, 3'b000, 5'd9, 64'h8000_0000, 64'd1);
        chk("mulw_flag", 64'(MulHoldFlag), 64'd1);
        feedDone(2, 128'h8000_0000);
        chk("mulw_data", RespData, 64'hFFFF_FFFF_8000_0000);
        step();
        issue(OPW, 3'b000, 5'd9, 64'h8000_0000, 64'd1);
        chk("mulw_rep_flag", 64'(MulHoldFlag), 64'd1);
        feedDone(1, 128'h8000_0000);
        chk("mulw_rep_data", RespData, 64'hFFFF_FFFF_8000_0000);
        step();

        // Flush in BUSY: MULH all-ones, then MUL all-ones must miss (cache invalidated)
        issue(OP64, 3'b001, 5'd10, ONES, ONES);
        chk("fl_flag_start", 64'(MulHoldFlag), 64'd1);
        step();
        Flush = 1'b1;
        #1;
        chk("fl_stall_busy", 64'(StallReq), 64'd1);
        step();
        Flush = 1'b0;
        chk("fl_abort_stall", 64'(StallReq), 64'd1);
        chk("fl_abort_flag", 64'(MulHoldFlag), 64'd0);
        chk("fl_abort_resp", 64'(RespValid), 64'd0);
        step();
        MulDone = 1'b1; MulProduct = {64'd0, 64'd1};
        #1;
        chk("fl_abort_stall2", 64'(StallReq), 64'd1);
        step();
        MulDone = 1'b0; MulProduct = '0;
        chk("fl_idle_stall", 64'(StallReq), 64'd0);
        chk("fl_idle_resp", 64'(RespValid), 64'd0);
        step();
        chk("fl_idle_resp2", 64'(RespValid), 64'd0);
        issue(OP64, 3'b000, 5'd11, ONES, ONES);
        chk("fl_rep_miss_flag", 64'(MulHoldFlag), 64'd1);
        chk("fl_rep_resp", 64'(RespValid), 64'd0);
        feedDone(1, {64'd0, 64'd1});
        chk("fl_rep_data", RespData, 64'd1);
        chk("fl_rep_rd", 64'(RespRd), 64'd11);
        step();

        // Watchdog: no MulDone for 64 BUSY cycles
        issue(OP64, 3'b000, 5'd12, 64'd2, 64'd2);
        step();
        for (int i = 1; i < 64; i++) step();
        chk("wd_last_busy_flag", 64'(MulHoldFlag), 64'd2);
        chk("wd_last_busy_tmo", 64'(TimeoutErr), 64'd0);
        step();
        chk("wd_tmo", 64'(TimeoutErr), 64'd1);
        chk("wd_stall", 64'(StallReq), 64'd0);
        chk("wd_flag", 64'(MulHoldFlag), 64'd0);
        chk("wd_resp", 64'(RespValid), 64'd0);
        step();
        chk("wd_tmo_sticky", 64'(TimeoutErr), 64'd1);

        // Asynchronous reset in BUSY
        issue(OP64, 3'b000, 5'd13, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD);
        step();
        chk("rs_busy_flag", 64'(MulHoldFlag), 64'd2);
        #1;
        Rst = 1'b0;
        #1;
        chk("rs_flag", 64'(MulHoldFlag), 64'd0);
        chk("rs_stall", 64'(StallReq), 64'd0);
        chk("rs_data", RespData, 64'd0);
        chk("rs_rd", 64'(RespRd), 64'd0);
        chk("rs_src1", MulSrc1, 64'd0);
        chk("rs_tmo", 64'(TimeoutErr), 64'd0);
        step();
        Rst = 1'b1;
        step();
        MulDone = 1'b1; MulProduct = {ONES, 64'hFFFF_FFFF_FFFF_FFE2};
        step();
        MulDone = 1'b0; MulProduct = '0;
        chk("rs_late_done_resp", 64'(RespValid), 64'd0);
        chk("rs_late_done_stall", 64'(StallReq), 64'd0);
        issue(OP64, 3'b000, 5'd14, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("rs_new_flag", 64'(MulHoldFlag), 64'd1);
        feedDone(3, {ONES, 64'hFFFF_FFFF_FFFF_FFE2});
        chk("rs_new_resp", 64'(RespValid), 64'd1);
        chk("rs_new_data", RespData, 64'hFFFF_FFFF_FFFF_FFE2);
        chk("rs_new_rd", 64'(RespRd), 64'd14);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
